// File: rtl/video_timing_pkg.sv
// Shared raster geometry, coordinate type and lock FSM states for the D8M loopback video path.
// Latency: none (declarations only).
// Backpressure: none; consumers advance on their own pixel strobe.
package video_timing_pkg;

  localparam int COORD_W = 13;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_TOTAL = 800;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BLANK = 160;

  localparam int V_TOTAL = 525;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BLANK = 45;

  localparam int V_LOCK_LINE = 0;
  localparam int MISS_LIMIT  = 2;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/video_pos_timing_gen_if.sv
// Pixel strobe and camera vsync in, raster counters and decoded timing out.
// Latency: none (wiring only).
// Backpressure: none; everything moves on pix_en.
interface video_pos_timing_gen_if;
  import video_timing_pkg::*;

  logic   pix_en;
  logic   ext_vs;
  coord_t x_count;
  coord_t y_count;
  coord_t col;
  coord_t row;
  logic   hs_n;
  logic   vs_n;
  logic   de;
  logic   line_start;
  logic   frame_start;
  logic   locked;

  modport master (
    input  pix_en, ext_vs,
    output x_count, y_count, col, row, hs_n, vs_n, de, line_start, frame_start, locked
  );

  modport slave (
    output pix_en, ext_vs,
    input  x_count, y_count, col, row, hs_n, vs_n, de, line_start, frame_start, locked
  );

endinterface

// File: rtl/vs_lock_fsm.sv
// Locks the raster phase to camera vsync rising edges; drops lock on repeated misses or silence.
// Latency: reload is combinational in the edge cycle; locked is registered with the counters.
// Backpressure: none; all state holds while pix_en is low.
module vs_lock_fsm
  import video_timing_pkg::*;
#(
  parameter int P_H_TOTAL     = H_TOTAL,
  parameter int P_V_TOTAL     = V_TOTAL,
  parameter int P_V_LOCK_LINE = V_LOCK_LINE,
  parameter int P_MISS_LIMIT  = MISS_LIMIT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   pix_en,
  input  logic   ext_vs,
  input  coord_t x_count,
  input  coord_t y_count,
  output logic   reload,
  output logic   locked
);

  // The natural roll onto the lock line happens from this position.
  localparam coord_t X_LAST    = coord_t'(P_H_TOTAL - 1);
  localparam coord_t Y_PREV    = coord_t'((P_V_LOCK_LINE + P_V_TOTAL - 1) % P_V_TOTAL);
  localparam logic [3:0] MISS_LAST = 4'(P_MISS_LIMIT - 1);
  localparam logic [1:0] TO_LAST   = 2'd1;

  lock_state_e state_q, state_d;
  logic [3:0]  miss_q, miss_d;
  logic [1:0]  to_q, to_d;
  logic        vs_dly_q, vs_dly_d;
  logic        edge_seen;
  logic        at_lock_pt;

  // Edge detect, miss/timeout bookkeeping and next-state decode.
  always_comb begin
    vs_dly_d   = pix_en ? ext_vs : vs_dly_q;
    edge_seen  = pix_en && ext_vs && !vs_dly_q;
    at_lock_pt = pix_en && (x_count == X_LAST) && (y_count == Y_PREV);
    state_d    = state_q;
    miss_d     = miss_q;
    to_d       = to_q;
    reload     = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (edge_seen) begin
          reload  = 1'b1;
          state_d = ST_LOCKED;
          miss_d  = '0;
          to_d    = '0;
        end
      end
      ST_LOCKED: begin
        if (edge_seen) begin
          to_d = '0;
          if (at_lock_pt) begin
            miss_d = '0;
          end else if (miss_q >= MISS_LAST) begin
            // Too many misses: give up without reloading; the next edge realigns.
            state_d = ST_SEARCH;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + 4'd1;
          end
        end else if (at_lock_pt) begin
          if (to_q >= TO_LAST) begin
            state_d = ST_SEARCH;
            to_d    = '0;
          end else begin
            to_d = to_q + 2'd1;
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SEARCH;
      miss_q   <= '0;
      to_q     <= '0;
      vs_dly_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      to_q     <= to_d;
      vs_dly_q <= vs_dly_d;
    end
  end

  assign locked = (state_q == ST_LOCKED);

endmodule

// File: rtl/video_pos_timing_gen.sv
// Raster counters, active-area coordinates and sync/de decodes, phase-locked to camera vsync.
// Latency: all outputs registered together; decodes are coherent with x_count/y_count.
// Backpressure: none; pix_en low freezes everything and suppresses the start pulses.
module video_pos_timing_gen
  import video_timing_pkg::*;
#(
  parameter int P_H_TOTAL     = H_TOTAL,
  parameter int P_H_FP        = H_FP,
  parameter int P_H_SYNC      = H_SYNC,
  parameter int P_H_BLANK     = H_BLANK,
  parameter int P_V_TOTAL     = V_TOTAL,
  parameter int P_V_FP        = V_FP,
  parameter int P_V_SYNC      = V_SYNC,
  parameter int P_V_BLANK     = V_BLANK,
  parameter int P_V_LOCK_LINE = V_LOCK_LINE,
  parameter int P_MISS_LIMIT  = MISS_LIMIT
) (
  input logic                    clk,
  input logic                    rst_n,
  video_pos_timing_gen_if.master vif
);

  localparam coord_t ONE     = coord_t'(1);
  localparam coord_t X_LAST  = coord_t'(P_H_TOTAL - 1);
  localparam coord_t Y_LAST  = coord_t'(P_V_TOTAL - 1);
  localparam coord_t Y_LOCK  = coord_t'(P_V_LOCK_LINE);
  localparam coord_t HS_BEG  = coord_t'(P_H_FP);
  localparam coord_t HS_END  = coord_t'(P_H_FP + P_H_SYNC);
  localparam coord_t VS_BEG  = coord_t'(P_V_FP);
  localparam coord_t VS_END  = coord_t'(P_V_FP + P_V_SYNC);
  localparam coord_t H_ACT   = coord_t'(P_H_BLANK);
  localparam coord_t V_ACT   = coord_t'(P_V_BLANK);
  // Blanking coordinates deliberately wrap high (e.g. 8032..8191); downstream relies on it.
  localparam coord_t COL_RST = coord_t'((1 << COORD_W) - P_H_BLANK);
  localparam coord_t ROW_RST = coord_t'((1 << COORD_W) - P_V_BLANK);

  coord_t x_q, x_d, y_q, y_d, col_q, col_d, row_q, row_d;
  logic   hs_n_q, hs_n_d, vs_n_q, vs_n_d, de_q, de_d;
  logic   line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic   reload;
  logic   locked;

  vs_lock_fsm #(
    .P_H_TOTAL     (P_H_TOTAL),
    .P_V_TOTAL     (P_V_TOTAL),
    .P_V_LOCK_LINE (P_V_LOCK_LINE),
    .P_MISS_LIMIT  (P_MISS_LIMIT)
  ) u_lock (
    .clk     (clk),
    .rst_n   (rst_n),
    .pix_en  (vif.pix_en),
    .ext_vs  (vif.ext_vs),
    .x_count (x_q),
    .y_count (y_q),
    .reload  (reload),
    .locked  (locked)
  );

  // Next counter values, then decodes taken from those next values so they register together.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vif.pix_en) begin
      if (reload) begin
        x_d = '0;
        y_d = Y_LOCK;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
    col_d         = x_d - H_ACT;
    row_d         = y_d - V_ACT;
    hs_n_d        = !((x_d >= HS_BEG) && (x_d < HS_END));
    vs_n_d        = !((y_d >= VS_BEG) && (y_d < VS_END));
    de_d          = (x_d >= H_ACT) && (y_d >= V_ACT);
    line_start_d  = vif.pix_en && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      col_q         <= COL_RST;
      row_q         <= ROW_RST;
      hs_n_q        <= 1'b1;
      vs_n_q        <= 1'b1;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      col_q         <= col_d;
      row_q         <= row_d;
      hs_n_q        <= hs_n_d;
      vs_n_q        <= vs_n_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vif.x_count     = x_q;
  assign vif.y_count     = y_q;
  assign vif.col         = col_q;
  assign vif.row         = row_q;
  assign vif.hs_n        = hs_n_q;
  assign vif.vs_n        = vs_n_q;
  assign vif.de          = de_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.locked      = locked;

endmodule

// File: tb/tb_video_pos_timing_gen.sv
// Directed bench for the raster timing generator: scoreboard queue filled by stimulus, drained by a monitor.
// Horizontal timing is the full 800-pixel line; vertical is shortened to 8 lines to keep frames short.
// Monitor samples on the falling edge; stimulus drives 1 time unit after the rising edge.
module tb_video_pos_timing_gen;

  localparam int HT  = 800;
  localparam int VT  = 8;
  localparam int FR  = HT * VT;
  localparam int HBL = 160;
  localparam int VBL = 4;

  localparam int S_X = 0, S_Y = 1, S_COL = 2, S_ROW = 3, S_HSN = 4, S_VSN = 5, S_DE = 6;
  localparam int S_LS = 7, S_FS = 8, S_LOCK = 9;
  localparam int S_CDE = 10, S_CHS = 11, S_CVS = 12, S_CLS = 13, S_CFS = 14, S_MARK = 15;

  typedef struct {
    int    cyc;
    int    sig;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, adv = 0;
  int   n_chk = 0, n_pass = 0;
  int   c_de = 0, c_hs = 0, c_vs = 0, c_ls = 0, c_fs = 0;
  exp_t m_e;
  int   m_act;

  video_pos_timing_gen_if vif ();

  video_pos_timing_gen #(
    .P_V_TOTAL (VT),
    .P_V_FP    (1),
    .P_V_SYNC  (2),
    .P_V_BLANK (VBL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push_exp(input int sig, input int val, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.exp  = val;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic mark();
    push_exp(S_MARK, 0, "mark");
  endtask

  task automatic chk_pos(input string nm);
    push_exp(S_X, adv % HT, {nm, "_x"});
    push_exp(S_Y, (adv / HT) % VT, {nm, "_y"});
  endtask

  task automatic push_reset_vals(input string nm);
    push_exp(S_X, 0, {nm, "_x"});
    push_exp(S_Y, 0, {nm, "_y"});
    push_exp(S_COL, 8192 - HBL, {nm, "_col"});
    push_exp(S_ROW, 8192 - VBL, {nm, "_row"});
    push_exp(S_HSN, 1, {nm, "_hs_n"});
    push_exp(S_VSN, 1, {nm, "_vs_n"});
    push_exp(S_DE, 0, {nm, "_de"});
    push_exp(S_LS, 0, {nm, "_line_start"});
    push_exp(S_FS, 0, {nm, "_frame_start"});
    push_exp(S_LOCK, 0, {nm, "_locked"});
  endtask

  // One clock; adv counts the pixel advances the bench requested.
  task automatic clk1();
    bit pe;
    pe = vif.pix_en;
    @(posedge clk);
    if (pe) adv++;
    #1;
  endtask

  task automatic run_to(input int target);
    vif.ext_vs = 1'b0;
    for (int i = 0; i < 40000 && adv < target; i++) clk1();
  endtask

  function automatic int dut_val(input int sig);
    int r;
    r = -1;
    case (sig)
      S_X:    r = int'(vif.x_count);
      S_Y:    r = int'(vif.y_count);
      S_COL:  r = int'(vif.col);
      S_ROW:  r = int'(vif.row);
      S_HSN:  r = int'(vif.hs_n);
      S_VSN:  r = int'(vif.vs_n);
      S_DE:   r = int'(vif.de);
      S_LS:   r = int'(vif.line_start);
      S_FS:   r = int'(vif.frame_start);
      S_LOCK: r = int'(vif.locked);
      S_CDE:  r = c_de;
      S_CHS:  r = c_hs;
      S_CVS:  r = c_vs;
      S_CLS:  r = c_ls;
      S_CFS:  r = c_fs;
      default: r = -1;
    endcase
    return r;
  endfunction

  // Monitor: compare every expectation due this cycle, then accumulate pulse/level counts.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      if (m_e.sig == S_MARK) begin
        c_de = 0; c_hs = 0; c_vs = 0; c_ls = 0; c_fs = 0;
      end else begin
        m_act = (m_e.cyc == cyc) ? dut_val(m_e.sig) : -1;
        n_chk++;
        if (m_act == m_e.exp) n_pass++;
        else $display("FAIL %s: actual %0d expected %0d (cycle %0d)", m_e.name, m_act, m_e.exp, cyc);
      end
    end
    c_de += int'(vif.de);
    c_hs += int'(!vif.hs_n);
    c_vs += int'(!vif.vs_n);
    c_ls += int'(vif.line_start);
    c_fs += int'(vif.frame_start);
  end

  initial begin
    vif.pix_en = 1'b0;
    vif.ext_vs = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_reset_vals("reset");
    n_chk++;
    if (vif.x_count == 13'd0) n_pass++;
    else $display("FAIL reset_direct_x: actual %0d expected 0", vif.x_count);
    n_chk++;
    if (vif.locked == 1'b0) n_pass++;
    else $display("FAIL reset_direct_locked: actual %0d expected 0", vif.locked);
    clk1();
    rst_n      = 1'b1;
    vif.pix_en = 1'b1;
    adv        = 0;

    // First line: x sweep, hsync window, col at the blank boundary.
    mark();
    for (int i = 0; i < HT; i++) begin
      push_exp(S_X, adv % HT, "line0_x");
      push_exp(S_HSN, (adv >= 16 && adv < 112) ? 0 : 1, "line0_hs_n");
      if (adv == 0)   push_exp(S_COL, 8032, "col_at_x0");
      if (adv == HBL) push_exp(S_COL, 0, "col_at_x160");
      clk1();
    end
    chk_pos("line1");
    push_exp(S_LS, 1, "line1_start");
    push_exp(S_CHS, 96, "hs_low_count");
    push_exp(S_CDE, 0, "line0_de_count");

    // One full frame of free running.
    mark();
    for (int i = 0; i < FR; i++) begin
      if (adv % HT == 0) begin
        push_exp(S_VSN, (((adv / HT) % VT) inside {1, 2}) ? 0 : 1, "line_vs_n");
        push_exp(S_LS, 1, "line_start");
      end
      if (adv == FR) begin
        chk_pos("frame_wrap");
        push_exp(S_FS, 1, "frame_start_pulse");
      end
      if (adv == VBL * HT + HBL - 1) push_exp(S_DE, 0, "de_before_active");
      if (adv == VBL * HT + HBL) begin
        push_exp(S_COL, 0, "active_col0");
        push_exp(S_ROW, 0, "active_row0");
        push_exp(S_DE, 1, "active_de");
      end
      clk1();
    end
    push_exp(S_CFS, 1, "frame_start_count");
    push_exp(S_CDE, 640 * (VT - VBL), "de_count");
    push_exp(S_CVS, 2 * HT, "vs_low_count");
    push_exp(S_CLS, VT, "line_start_count");

    // Lock from SEARCH at (300,6).
    run_to(FR + 6 * HT + 300);
    chk_pos("pre_lock");
    push_exp(S_LOCK, 0, "pre_lock_locked");
    vif.ext_vs = 1'b1;
    clk1();
    adv = 0;
    chk_pos("lock_reload");
    push_exp(S_LOCK, 1, "lock_locked");
    push_exp(S_FS, 1, "lock_frame_start");
    n_chk++;
    if (vif.locked == 1'b1) n_pass++;
    else $display("FAIL lock_direct_locked: actual %0d expected 1", vif.locked);
    n_chk++;
    if (vif.x_count == 13'd0) n_pass++;
    else $display("FAIL lock_direct_x: actual %0d expected 0", vif.x_count);

    // Edges exactly one frame apart stay locked.
    for (int k = 1; k <= 2; k++) begin
      run_to(k * FR - 1);
      push_exp(S_LOCK, 1, "aligned_pre_locked");
      vif.ext_vs = 1'b1;
      clk1();
      chk_pos("aligned");
      push_exp(S_LOCK, 1, "aligned_locked");
    end

    // Two edges 5 pixels late: first tolerated, second drops lock; neither reloads.
    run_to(3 * FR + 4);
    vif.ext_vs = 1'b1;
    clk1();
    chk_pos("miss1");
    push_exp(S_LOCK, 1, "miss1_locked");
    run_to(4 * FR + 4);
    vif.ext_vs = 1'b1;
    clk1();
    chk_pos("miss2");
    push_exp(S_LOCK, 0, "miss2_locked");
    run_to(5 * FR + 4);
    vif.ext_vs = 1'b1;
    clk1();
    adv = 0;
    chk_pos("realign");
    push_exp(S_LOCK, 1, "realign_locked");

    // Silence for two frames: lock drops, counters free-run.
    run_to(FR);
    push_exp(S_LOCK, 1, "timeout_one_frame");
    run_to(2 * FR - 1);
    push_exp(S_LOCK, 1, "timeout_before");
    clk1();
    chk_pos("timeout_free_run");
    push_exp(S_LOCK, 0, "timeout_locked");

    // pix_en every other clock.
    mark();
    for (int i = 0; i < 2 * HT - 1; i++) begin
      push_exp(S_X, adv % HT, "half_rate_x");
      if (adv % HT == 0) push_exp(S_LS, (i % 2 == 0) ? 1 : 0, "half_rate_ls");
      vif.pix_en = (i % 2 == 0);
      clk1();
    end
    chk_pos("half_rate_line");
    push_exp(S_LS, 1, "half_rate_ls_new");
    push_exp(S_CLS, 1, "half_rate_ls_count");
    vif.pix_en = 1'b0;
    vif.ext_vs = 1'b1;
    clk1();
    chk_pos("edge_held");
    push_exp(S_LS, 0, "edge_held_ls");
    push_exp(S_LOCK, 0, "edge_held_locked");
    vif.pix_en = 1'b1;
    clk1();
    adv = 0;
    chk_pos("edge_taken");
    push_exp(S_LOCK, 1, "edge_taken_locked");
    push_exp(S_FS, 1, "edge_taken_fs");

    // Asynchronous reset mid-frame while locked.
    run_to(5 * HT + 499);
    chk_pos("pre_reset");
    push_exp(S_LOCK, 1, "pre_reset_locked");
    push_exp(S_DE, 1, "pre_reset_de");
    push_exp(S_COL, 339, "pre_reset_col");
    clk1();
    rst_n      = 1'b0;
    vif.pix_en = 1'b0;
    push_reset_vals("async_reset");
    clk1();
    clk1();
    rst_n      = 1'b1;
    vif.pix_en = 1'b1;
    adv        = 0;
    chk_pos("post_reset");
    push_exp(S_LOCK, 0, "post_reset_locked");
    n_chk++;
    if (vif.locked == 1'b0) n_pass++;
    else $display("FAIL post_reset_direct_locked: actual %0d expected 0", vif.locked);
    n_chk++;
    if (vif.x_count == 13'd0) n_pass++;
    else $display("FAIL post_reset_direct_x: actual %0d expected 0", vif.x_count);
    clk1();
    chk_pos("post_reset_step");
    run_to(10);
    chk_pos("post_reset_run");
    push_exp(S_LOCK, 0, "post_reset_run_locked");

    clk1();
    clk1();
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_chk++;
      $display("FAIL %s: never compared, expected %0d", m_e.name, m_e.exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_pos_timing_gen.md
Name: video_pos_timing_gen

Overview:
- Pixel-rate raster timing generator for the D8M loopback path.
- Produces the free-running VGA counters `x_count`/`y_count` and the active-area coordinates `col`/`row`.
- The downstream row-shift enable generator and the window/filter stages consume `col` and `x_count` directly.
- Locks the raster phase to the camera vertical sync, so the active area stays aligned with the incoming frame.

Parameters:
- H_TOTAL, 800, pixels per line (`x_count` range 0..H_TOTAL-1)
- H_FP, 16, horizontal front porch, starting at `x_count`=0
- H_SYNC, 96, hsync width, immediately after H_FP
- H_BLANK, 160, first active `x_count`; `col`=0 there
- V_TOTAL, 525, lines per frame
- V_FP, 10, vertical front porch, starting at `y_count`=0
- V_SYNC, 2, vsync width, immediately after V_FP
- V_BLANK, 45, first active `y_count`; `row`=0 there
- V_LOCK_LINE, 0, `y_count` loaded on a camera vsync rising edge
- MISS_LIMIT, 2, consecutive misaligned edges before dropping lock

Ports:
- clk in 1 pixel clock
- rst_n in 1 asynchronous active-low reset
- pix_en in 1 pixel-advance strobe; all state advances only when 1
- ext_vs in 1 camera vsync, level, already synchronous to `clk`
- x_count out 13 horizontal counter
- y_count out 13 vertical counter
- col out 13 (`x_count` - H_BLANK) mod 8192
- row out 13 (`y_count` - V_BLANK) mod 8192
- hs_n out 1 active-low hsync
- vs_n out 1 active-low vsync
- de out 1 active-area flag
- line_start out 1 one-`clk` pulse when `x_count`=0
- frame_start out 1 one-`clk` pulse when `x_count`=0 and `y_count`=0
- locked out 1 raster phase locked to `ext_vs`

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - `x_count`, `y_count` = 0; `col` = 8192-H_BLANK (8032); `row` = 8192-V_BLANK (8147).
  - `hs_n` = `vs_n` = 1; `de` = 0; `line_start` = `frame_start` = 0; `locked` = 0.
  - FSM in SEARCH; `miss_cnt` = 0; `vs_d` = 0.
- All outputs are registered and are coherent in the same cycle as `x_count`/`y_count`. There is no extra latency between the counters and the decoded outputs.
- Counters, on each `clk` with `pix_en`=1:
  - `x_count` increments; at H_TOTAL-1 it wraps to 0 and `y_count` increments.
  - `y_count` wraps from V_TOTAL-1 to 0.
- Counters, on `clk` with `pix_en`=0:
  - All registers hold.
  - `line_start` and `frame_start` are forced to 0, so each pulse lasts exactly one `clk`.
- `col`/`row` arithmetic: 13-bit subtraction with wrap. Blanking columns therefore read above 8000 (8032..8191), which downstream logic relies on.
- Decodes:
  - `hs_n` = 0 iff H_FP <= `x_count` < H_FP+H_SYNC.
  - `vs_n` = 0 iff V_FP <= `y_count` < V_FP+V_SYNC.
  - `de` = 1 iff `x_count` >= H_BLANK and `y_count` >= V_BLANK.
- Edge detect: `vs_d` samples `ext_vs` on `pix_en` cycles. A rising edge is `ext_vs` & !`vs_d` with `pix_en`=1. Edges while `pix_en`=0 are not seen until the next `pix_en` cycle; the level is held.
- FSM states: SEARCH, LOCKED.
- SEARCH:
  - On an edge, the next counter values are `x_count`=0 and `y_count`=V_LOCK_LINE; the decodes follow.
  - Go to LOCKED; `locked`=1; `miss_cnt`=0.
- LOCKED, edge arrives:
  - Aligned = the edge occurs when the counters are at (H_TOTAL-1, V_LOCK_LINE-1 mod V_TOTAL), i.e. the natural roll lands on the lock point.
  - Aligned: `miss_cnt`=0 and counting is normal.
  - Misaligned: `miss_cnt`++ and the counters are NOT reloaded.
  - When `miss_cnt` reaches MISS_LIMIT: go to SEARCH, `locked`=0, no reload on that edge. The next edge realigns.
- LOCKED, timeout: if there is no edge for 2 full frames (`y_count` rolls through V_LOCK_LINE twice without an edge), go to SEARCH with `locked`=0. The counters keep free-running.
- Simultaneous events: an edge on the wrap cycle is treated as aligned. A reload takes priority over the normal increment.
- Reset mid-frame: immediate asynchronous return to the reset values. The raster restarts at (0,0) and the FSM is in SEARCH.

Decomposition:
- Shared package `video_timing_pkg`:
  - Localparams: H/V totals, porches and blank widths, the 13-bit coordinate width.
  - An enum for the lock FSM states.
  - These are shared with the row-shift enable generator and the window stages.
- One sub-module, `vs_lock_fsm`:
  - Contains edge detect, the miss counter, the frame-timeout counter and the state register.
  - Outputs `reload` and `locked`.
- The parent holds the counters and the decodes.

Test Plan:
- Reset released, `pix_en`=1, `ext_vs`=0 for 800 clocks:
  - `x_count` runs 0..799 and wraps; `y_count` = 1 afterwards.
  - `col` = 8032 at `x`=0 and 0 at `x`=160; `de` stays 0 (`y`<45).
  - `hs_n` = 0 exactly for `x` 16..111.
- Free run for 420000 clocks (one frame):
  - `frame_start` gives exactly one pulse at (0,0).
  - `vs_n` = 0 for `y` 10..11.
  - `de` asserted for 640×480 = 307200 cycles.
- Drive an `ext_vs` rise at (x=300, y=200) in SEARCH:
  - Next cycle is (0,0) with `locked`=1.
  - Edges at 420000-clock period keep `locked`=1 with no reload.
- While LOCKED, shift `ext_vs` phase by 5 pixels for two consecutive frames:
  - First edge: `locked` stays 1.
  - Second edge: `locked`=0 and there is no reload.
  - Third edge: realign to (0,0) and `locked`=1.
- Toggle `pix_en` 1-of-2 cycles:
  - Counters advance every other `clk`.
  - `line_start` is one `clk` wide per line; `ext_vs` rising during a `pix_en`=0 cycle is taken on the next `pix_en` cycle.
- Assert `rst_n`=0 at (x=500, y=300) while LOCKED:
  - Outputs go to reset values asynchronously.
  - After release, counting restarts at (0,0) with `locked`=0.
